// File: rtl/tx_packetizer.sv
// Frames a 32-bit payload stream into header/payload/trailer packets for the
// Ethernet streaming transmitter, honouring its tx_stop backpressure.
module tx_packetizer #(
  parameter int PAYLOAD_WORDS = 364
) (
  input  logic        usr_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] pix_data,
  input  logic        pix_valid,
  input  logic        pix_last,
  output logic        pix_ready,
  output logic [31:0] tx_data,
  output logic [3:0]  tx_eof,
  output logic        tx_we,
  input  logic        tx_stop,
  output logic [15:0] frame_id,
  output logic [31:0] pkt_count
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    TRAILER
  } state_t;

  localparam logic [16:0] PKT_WORDS = 17'(PAYLOAD_WORDS);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pkt_id;
  logic [15:0] word_cnt;
  logic        last_pkt;
  logic        want_write;
  logic [16:0] cnt_inc;
  logic        pkt_full;
  logic        hdr_commit;
  logic        pay_accept;
  logic        pay_end;
  logic        trl_commit;

  // Counted one wider so PAYLOAD_WORDS=65535 compares without overflow.
  assign cnt_inc  = {1'b0, word_cnt} + 17'd1;
  assign pkt_full = (cnt_inc == PKT_WORDS);

  assign tx_we      = want_write & ~tx_stop;
  assign hdr_commit = (state == HDR) & tx_we;
  assign pay_accept = (state == PAYLOAD) & tx_we;
  assign pay_end    = pay_accept & (pix_last | pkt_full);
  assign trl_commit = (state == TRAILER) & tx_we;

  always_ff @(posedge usr_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are purely combinational from state so a stalled word stays put.
  always_comb begin
    state_nxt  = state;
    want_write = 1'b0;
    tx_data    = 32'd0;
    tx_eof     = 4'd0;
    pix_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && pix_valid) begin
          state_nxt = HDR;
        end
      end
      HDR: begin
        want_write = 1'b1;
        tx_data    = {frame_id, pkt_id};
        if (!tx_stop) begin
          state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        want_write = pix_valid;
        tx_data    = pix_data;
        pix_ready  = ~tx_stop;
        if (pay_end) begin
          state_nxt = TRAILER;
        end
      end
      TRAILER: begin
        want_write = 1'b1;
        tx_data    = {last_pkt, 15'd0, word_cnt};
        tx_eof     = 4'b0001;
        if (!tx_stop) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge usr_clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt <= 16'd0;
      last_pkt <= 1'b0;
    end else begin
      if (hdr_commit) begin
        word_cnt <= 16'd0;
      end else if (pay_accept) begin
        word_cnt <= cnt_inc[15:0];
      end
      if (pay_end) begin
        last_pkt <= pix_last;
      end
    end
  end

  // A frame's final packet advances frame_id and restarts packet numbering.
  always_ff @(posedge usr_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_id  <= 16'd0;
      pkt_id    <= 16'd0;
      pkt_count <= 32'd0;
    end else if (trl_commit) begin
      pkt_count <= pkt_count + 32'd1;
      if (last_pkt) begin
        frame_id <= frame_id + 16'd1;
        pkt_id   <= 16'd0;
      end else begin
        pkt_id <= pkt_id + 16'd1;
      end
    end
  end

endmodule

// File: doc/tx_packetizer.md
Name: tx_packetizer

Overview:
- Upstream neighbour of the Ethernet streaming transmitter. It runs in the user clock domain and takes a stream of 32-bit payload words.
- Cuts the stream into packets, each with a one-word header and a one-word trailer. Drives the transmitter's 32-bit write interface (tx_data/tx_eof/tx_we) and honours its tx_stop backpressure.
- The transmitter adds the MAC header and CRC. This block defines the payload framing only.

Parameters:
- PAYLOAD_WORDS, 364, maximum payload words per packet (1..65535); default gives 1464-byte payload incl. header/trailer.

Ports:
- usr_clk  in  1  block clock (user clock domain).
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  permits a new packet to start; sampled only in IDLE.
- pix_data  in  32  payload word.
- pix_valid  in  1  pix_data valid.
- pix_last  in  1  qualifies pix_valid; marks the final word of a frame.
- pix_ready  out  1  payload word accepted this cycle when pix_valid & pix_ready.
- tx_data  out  32  word to transmitter; byte lane 3 (tx_data[31:24]) is sent first on the wire.
- tx_eof  out  4  per-byte end-of-packet flag, lane-aligned with tx_data.
- tx_we  out  1  write strobe to transmitter FIFO.
- tx_stop  in  1  transmitter FIFO full; no write may occur while high.
- frame_id  out  16  current frame number.
- pkt_count  out  32  total packets completed since reset; wraps.

Behaviour:
- Reset values: tx_we=0, pix_ready=0, tx_eof=0, tx_data=0, frame_id=0, pkt_count=0, internal pkt_id=0, word_cnt=0, state=IDLE.
- Write rule: tx_we = want_write & ~tx_stop, combinational from state and tx_stop. A word is committed only in a cycle with tx_we=1. Otherwise the state holds and retries the next cycle.
- pix_ready = (state==PAYLOAD) & ~tx_stop. Ready is independent of pix_valid.
- States:
  - IDLE: want_write=0. If enable & pix_valid, go to HDR next cycle. No payload is consumed.
  - HDR: want_write=1, tx_data={frame_id, pkt_id}, tx_eof=0. On commit, clear word_cnt and go to PAYLOAD.
  - PAYLOAD: want_write=pix_valid, tx_data=pix_data, tx_eof=0, pix_ready as above.
    - On accept, word_cnt increments.
    - If pix_last is set, or word_cnt+1==PAYLOAD_WORDS, latch last_pkt=pix_last and go to TRAILER.
    - pix_valid low inserts bubbles (tx_we=0) with no other effect.
  - TRAILER: want_write=1, tx_data={last_pkt, 15'b0, word_cnt[15:0]}, tx_eof=4'b0001 (EOF on the final byte, lane 0). On commit:
    - pkt_count increments.
    - If last_pkt: frame_id increments and pkt_id clears.
    - Else pkt_id increments.
    - Go to IDLE.
- Minimum one idle cycle between packets. Packet length on the wire is 4*(word_cnt+2) bytes.
- word_cnt in the trailer is the payload word count, range 1..PAYLOAD_WORDS. Zero-payload packets never occur, because a packet starts only on pix_valid.
- pix_last on word PAYLOAD_WORDS: a single trailer with last_pkt=1. No extra empty packet is produced.
- enable deasserted mid-packet: the current packet completes normally. No new packet starts until enable returns.
- tx_stop high in HDR/TRAILER: the word is held stable (tx_data/tx_eof constant) until tx_stop drops.
- frame_id, pkt_id (16-bit) and pkt_count (32-bit) wrap silently.
- Reset mid-packet: immediate return to reset values.
  - The transmitter FIFO shares reset_n, so no partial packet survives.
  - Upstream must also restart its frame.

Test Plan:
- PAYLOAD_WORDS=4, enable=1, 10 words, pix_last on word 10, tx_stop=0 -> three packets:
  - hdr {0,0}, 4 words, trailer 32'h0000_0004.
  - hdr {0,1}, 4 words, trailer 32'h0000_0004.
  - hdr {0,2}, 2 words, trailer 32'h8000_0002.
  - After the third packet, frame_id=1 and pkt_count=3. tx_eof=4'b0001 only on trailers.
- PAYLOAD_WORDS=4, exactly 4 words with pix_last on word 4 -> one packet; trailer 32'h8000_0004; next header {1,0}.
- tx_stop held high for 5 cycles during HDR, then during mid-PAYLOAD -> tx_we=0 and pix_ready=0 throughout each stall. Header value stays constant. No word is lost or duplicated; the output sequence is identical to the unstalled run.
- pix_valid toggling 1/0 every cycle in PAYLOAD -> tx_we follows accepts only; trailer word count matches the accepted words.
- enable dropped after the header of packet 0 -> packet 0 completes. No header appears until enable=1 again, then the next header is {0,1}.
- reset_n pulsed low mid-PAYLOAD (async, between edges) -> outputs zero immediately. After release, the first header is {0,0} and pkt_count=0.
